// File: rtl/beat_sequencer_if.sv
// Beat bus and instruction-fetch bus between the beat generator/memory side and the sequencer.
interface beat_sequencer_if #(
    parameter int unsigned IW = 16
);
    logic          t0;
    logic          t1;
    logic          t2;
    logic          t3;
    logic [IW-1:0] instr_in;
    logic          mem_ready;
    logic          mem_rd;

    modport master (
        output t0, t1, t2, t3, instr_in, mem_ready,
        input  mem_rd
    );

    modport slave (
        input  t0, t1, t2, t3, instr_in, mem_ready,
        output mem_rd
    );
endinterface

// File: rtl/beat_sequencer.sv
// Beat-driven instruction sequencer: T0 fetch, T1 decode, T2 execute, T3 writeback; owns PC/IR.
// Optional macro BEAT_CHECK_EN enables beat-protocol checking with a sticky error and ERR state.
module beat_sequencer #(
    parameter int unsigned   AW       = 8,
    parameter int unsigned   IW       = 16,
    parameter int unsigned   CW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    beat_sequencer_if.slave bus,
    input  logic          i_halt_req,
    input  logic          i_resume,
    output logic          o_ir_load,
    output logic          o_dec_en,
    output logic          o_alu_en,
    output logic          o_reg_we,
    output logic [AW-1:0] o_pc,
    output logic [IW-1:0] o_ir,
    output logic [CW-1:0] o_instr_cnt,
    output logic [CW-1:0] o_stall_cnt,
    output logic [1:0]    o_state,
    output logic          o_halted,
    output logic          o_beat_err
);

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [IW-1:0] r_ir;
    logic [CW-1:0] r_instr_cnt;
    logic [CW-1:0] r_stall_cnt;
    logic          r_fetch_ok;
    logic          r_ir_load;
    logic          r_dec_en;
    logic          r_alu_en;
    logic          r_reg_we;

    logic [3:0]    w_beat;
    logic          w_b0;
    logic          w_b1;
    logic          w_b2;
    logic          w_b3;
    logic          w_viol;
    logic          w_fetch;

    assign w_beat = {bus.t3, bus.t2, bus.t1, bus.t0};

    // Priority resolution t0 > t1 > t2 > t3 for overlapping beats
    assign w_b0 = bus.t0;
    assign w_b1 = bus.t1 & ~bus.t0;
    assign w_b2 = bus.t2 & ~bus.t1 & ~bus.t0;
    assign w_b3 = bus.t3 & ~bus.t2 & ~bus.t1 & ~bus.t0;

`ifdef BEAT_CHECK_EN
    logic [3:0] r_prev;
    logic       r_beat_err;

    // Armed in RUN/HALT: each edge must carry the left-rotate of the previous beat
    assign w_viol = ((r_state == S_RUN) || (r_state == S_HALT)) &&
                    (w_beat != {r_prev[2:0], r_prev[3]});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev     <= 4'b0001;
            r_beat_err <= 1'b0;
        end else begin
            if (w_viol) begin
                r_beat_err <= 1'b1;
            end
            if ((r_state == S_SYNC) && w_b0) begin
                r_prev <= 4'b0001;
            end else if (((r_state == S_RUN) || (r_state == S_HALT)) && !w_viol) begin
                r_prev <= w_beat;
            end
        end
    end

    assign o_beat_err = r_beat_err;
`else
    assign w_viol     = 1'b0;
    assign o_beat_err = 1'b0;
`endif

    assign w_fetch    = w_b0 && ((r_state == S_SYNC) || ((r_state == S_RUN) && !w_viol));
    assign bus.mem_rd = ((r_state == S_SYNC) || (r_state == S_RUN)) && bus.t0 && !o_beat_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_SYNC;
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_instr_cnt <= '0;
            r_stall_cnt <= '0;
            r_fetch_ok  <= 1'b0;
            r_ir_load   <= 1'b0;
            r_dec_en    <= 1'b0;
            r_alu_en    <= 1'b0;
            r_reg_we    <= 1'b0;
        end else begin
            r_ir_load <= 1'b0;
            r_dec_en  <= 1'b0;
            r_alu_en  <= 1'b0;
            r_reg_we  <= 1'b0;

            // A stalled fetch clears fetch_ok, which suppresses the rest of the cycle
            if (w_fetch) begin
                if (bus.mem_ready) begin
                    r_ir       <= bus.instr_in;
                    r_fetch_ok <= 1'b1;
                    r_ir_load  <= 1'b1;
                end else begin
                    r_fetch_ok  <= 1'b0;
                    r_stall_cnt <= (r_stall_cnt == CNT_MAX) ? r_stall_cnt : r_stall_cnt + CW'(1);
                end
            end

            unique case (r_state)
                S_SYNC: begin
                    if (w_b0) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_viol) begin
                        r_state <= S_ERR;
                    end else begin
                        if (w_b1 && r_fetch_ok) r_dec_en <= 1'b1;
                        if (w_b2 && r_fetch_ok) r_alu_en <= 1'b1;
                        if (w_b3) begin
                            if (r_fetch_ok) begin
                                r_reg_we    <= 1'b1;
                                r_pc        <= r_pc + AW'(1);
                                r_instr_cnt <= (r_instr_cnt == CNT_MAX) ? r_instr_cnt
                                                                        : r_instr_cnt + CW'(1);
                            end
                            if (i_halt_req) begin
                                r_state <= S_HALT;
                            end
                        end
                    end
                end
                S_HALT: begin
                    if (w_viol) begin
                        r_state <= S_ERR;
                    end else if (i_resume) begin
                        r_state <= S_SYNC;
                    end
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
            endcase
        end
    end

    assign o_ir_load   = r_ir_load;
    assign o_dec_en    = r_dec_en;
    assign o_alu_en    = r_alu_en;
    assign o_reg_we    = r_reg_we;
    assign o_pc        = r_pc;
    assign o_ir        = r_ir;
    assign o_instr_cnt = r_instr_cnt;
    assign o_stall_cnt = r_stall_cnt;
    assign o_state     = 2'(r_state);
    assign o_halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_beat_sequencer.sv
// Scoreboard bench for beat_sequencer: expected per-cycle outputs are queued as beats are driven.
module tb_beat_sequencer;

    localparam int unsigned AW = 4;
    localparam int unsigned IW = 16;
    localparam int unsigned CW = 16;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          halt_req = 1'b0;
    logic          resume   = 1'b0;
    logic          o_ir_load, o_dec_en, o_alu_en, o_reg_we, o_halted, o_beat_err;
    logic [AW-1:0] o_pc;
    logic [IW-1:0] o_ir;
    logic [CW-1:0] o_instr_cnt, o_stall_cnt;
    logic [1:0]    o_state;

    beat_sequencer_if #(.IW(IW)) bif ();

    beat_sequencer #(.AW(AW), .IW(IW), .CW(CW), .RESET_PC(4'd0)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bif),
        .i_halt_req  (halt_req),
        .i_resume    (resume),
        .o_ir_load   (o_ir_load),
        .o_dec_en    (o_dec_en),
        .o_alu_en    (o_alu_en),
        .o_reg_we    (o_reg_we),
        .o_pc        (o_pc),
        .o_ir        (o_ir),
        .o_instr_cnt (o_instr_cnt),
        .o_stall_cnt (o_stall_cnt),
        .o_state     (o_state),
        .o_halted    (o_halted),
        .o_beat_err  (o_beat_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          il;
        logic          de;
        logic          ae;
        logic          rw;
        logic [AW-1:0] pc;
        logic [IW-1:0] ir;
        logic [CW-1:0] ic;
        logic [CW-1:0] sc;
        logic [1:0]    st;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    exp_t          m_e;
    int            n_tests = 0;
    int            n_fail  = 0;

    // Transaction-level expectation of the architectural state
    logic [AW-1:0] e_pc  = '0;
    logic [IW-1:0] e_ir  = '0;
    logic [CW-1:0] e_ic  = '0;
    logic [CW-1:0] e_sc  = '0;
    logic [1:0]    e_st  = 2'd0;
    logic          e_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            m_e = sb.pop_front();
            check("ir_load",   32'(o_ir_load),   32'(m_e.il));
            check("dec_en",    32'(o_dec_en),    32'(m_e.de));
            check("alu_en",    32'(o_alu_en),    32'(m_e.ae));
            check("reg_we",    32'(o_reg_we),    32'(m_e.rw));
            check("pc",        32'(o_pc),        32'(m_e.pc));
            check("ir",        32'(o_ir),        32'(m_e.ir));
            check("instr_cnt", 32'(o_instr_cnt), 32'(m_e.ic));
            check("stall_cnt", 32'(o_stall_cnt), 32'(m_e.sc));
            check("state",     32'(o_state),     32'(m_e.st));
            check("halted",    32'(o_halted),    32'(m_e.st == 2'd2));
            check("beat_err",  32'(o_beat_err),  32'(m_e.err));
        end
    end

    task automatic push(input logic il, input logic de, input logic ae, input logic rw);
        exp_t x;
        x.il  = il;
        x.de  = de;
        x.ae  = ae;
        x.rw  = rw;
        x.pc  = e_pc;
        x.ir  = e_ir;
        x.ic  = e_ic;
        x.sc  = e_sc;
        x.st  = e_st;
        x.err = e_err;
        sb.push_back(x);
    endtask

    task automatic drv(input logic [3:0] b, input logic rdy, input logic [IW-1:0] ins,
                       input logic hreq, input logic res, input logic rst, input logic exp_mrd);
        @(negedge clk);
        {bif.t3, bif.t2, bif.t1, bif.t0} = b;
        bif.mem_ready = rdy;
        bif.instr_in  = ins;
        halt_req      = hreq;
        resume        = res;
        reset         = rst;
        #1 check("mem_rd", 32'(bif.mem_rd), 32'(exp_mrd));
    endtask

    task automatic do_reset(input logic [3:0] b, input logic exp_mrd);
        drv(b, 1'b0, '0, 1'b0, 1'b0, 1'b1, exp_mrd);
        e_pc  = '0;
        e_ir  = '0;
        e_ic  = '0;
        e_sc  = '0;
        e_st  = 2'd0;
        e_err = 1'b0;
        push(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One full T0..T3 instruction cycle starting from SYNC or RUN
    task automatic instr(input logic rdy, input logic [IW-1:0] ins, input logic hreq);
        drv(4'b0001, rdy, ins, 1'b0, 1'b0, 1'b0, 1'b1);
        e_st = 2'd1;
        if (rdy) e_ir = ins;
        else     e_sc = e_sc + CW'(1);
        push(rdy, 1'b0, 1'b0, 1'b0);
        drv(4'b0010, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, rdy, 1'b0, 1'b0);
        drv(4'b0100, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, rdy, 1'b0);
        drv(4'b1000, 1'b1, '0, hreq, 1'b0, 1'b0, 1'b0);
        if (rdy) begin
            e_pc = e_pc + AW'(1);
            e_ic = e_ic + CW'(1);
        end
        if (hreq) e_st = 2'd2;
        push(1'b0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        {bif.t3, bif.t2, bif.t1, bif.t0} = 4'b0000;
        bif.mem_ready = 1'b0;
        bif.instr_in  = '0;

        // Basic free-running instruction cycles
        do_reset(4'b0000, 1'b0);
        repeat (4) instr(1'b1, 16'h1234, 1'b0);

        // Stalled fetch on the second T0
        do_reset(4'b0000, 1'b0);
        instr(1'b1, 16'hA001, 1'b0);
        instr(1'b0, 16'hDEAD, 1'b0);
        instr(1'b1, 16'hA002, 1'b0);

        // Halt on T3, halt_req ignored in HALT, resume back to SYNC
        instr(1'b1, 16'hB003, 1'b1);
        drv(4'b0001, 1'b1, 16'hC0DE, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0);
        drv(4'b0010, 1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        e_st = 2'd0;
        push(1'b0, 1'b0, 1'b0, 1'b0);
        drv(4'b0100, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0);
        drv(4'b1000, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0);
        instr(1'b1, 16'hB004, 1'b0);

        // PC wrap with a 4-bit PC
        do_reset(4'b0000, 1'b0);
        for (int i = 0; i < 16; i++) instr(1'b1, 16'(16'h5000 + i), 1'b0);

        // Reset in the middle of an instruction (during T2)
        instr(1'b1, 16'h6000, 1'b0);
        drv(4'b0001, 1'b1, 16'h6001, 1'b0, 1'b0, 1'b0, 1'b1);
        e_ir = 16'h6001;
        push(1'b1, 1'b0, 1'b0, 1'b0);
        drv(4'b0010, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b0, 1'b0);
        do_reset(4'b0100, 1'b0);
        drv(4'b1000, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0);
        instr(1'b1, 16'h6002, 1'b0);

        // Beat-protocol violations
        do_reset(4'b0000, 1'b0);
`ifdef BEAT_CHECK_EN
        drv(4'b0001, 1'b1, 16'h7001, 1'b0, 1'b0, 1'b0, 1'b1);
        e_ir = 16'h7001;
        e_st = 2'd1;
        push(1'b1, 1'b0, 1'b0, 1'b0);
        drv(4'b0100, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_err = 1'b1;
        e_st  = 2'd3;
        push(1'b0, 1'b0, 1'b0, 1'b0);
        drv(4'b1000, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0);
        drv(4'b0001, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0);
        do_reset(4'b0000, 1'b0);
        drv(4'b0001, 1'b1, 16'h7002, 1'b0, 1'b0, 1'b0, 1'b1);
        e_ir = 16'h7002;
        e_st = 2'd1;
        push(1'b1, 1'b0, 1'b0, 1'b0);
        drv(4'b0110, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_err = 1'b1;
        e_st  = 2'd3;
        push(1'b0, 1'b0, 1'b0, 1'b0);
        do_reset(4'b0000, 1'b0);
`else
        drv(4'b0001, 1'b1, 16'h7001, 1'b0, 1'b0, 1'b0, 1'b1);
        e_ir = 16'h7001;
        e_st = 2'd1;
        push(1'b1, 1'b0, 1'b0, 1'b0);
        drv(4'b0100, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b1, 1'b0);
        drv(4'b0110, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b0, 1'b0);
        drv(4'b1000, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_pc = e_pc + AW'(1);
        e_ic = e_ic + CW'(1);
        push(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        @(posedge clk);
        #3;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
